// File: rtl/internal_defines.sv
`default_nettype none
// ============================================================================
//  Module      : internal_defines (package)
//  Description : Shared types for the processing element: operation codes,
//                the demuxed control word and the FSM state encoding.
//  Contents    : pe_op_t        - 3-bit operation code
//                ctrl_signals_t - packed control word (carries op)
//                pe_state_t     - processing-element FSM states
//                is_multi_cycle - true for ops that run through EXEC
//  Revision    : 1.0 - initial release
// ============================================================================
package internal_defines;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    AND  = 3'd3,
    OR   = 3'd4,
    XOR  = 3'd5,
    MUL  = 3'd6,
    PASS = 3'd7
  } pe_op_t;

  typedef struct packed {
    pe_op_t op;
  } ctrl_signals_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } pe_state_t;

  function automatic logic is_multi_cycle(input pe_op_t op);
    return (op == MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : pe_multiplier
//  Description : Unsigned shift-add multiplier. A start pulse loads the
//                operands; one partial product is accumulated per clock for
//                exactly DATA_W clocks. done is high during the clock whose
//                rising edge performs the final iteration, so product is
//                complete right after that edge and holds until next start.
//  Ports       : clock   - rising-edge clock
//                reset   - asynchronous active-high reset
//                start   - load operands and begin (only while idle)
//                a, b    - DATA_W-bit unsigned operands
//                done    - final iteration happens on the coming edge
//                product - 2*DATA_W-bit accumulated product
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_multiplier #(
  parameter int DATA_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic                busy_q,   busy_d;
  logic [CNT_W-1:0]    iter_q,   iter_d;
  logic [2*DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q,    acc_d;

  assign done    = busy_q && (iter_q == CNT_W'(DATA_W - 1));
  assign product = acc_q;

  always_comb begin
    busy_d   = busy_q;
    iter_d   = iter_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      iter_d   = '0;
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      // Add the shifted multiplicand for each set multiplier bit, LSB first.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      iter_d   = iter_q + CNT_W'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      iter_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      iter_q   <= iter_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/processing_element.sv
`default_nettype none
// ============================================================================
//  Module      : processing_element
//  Description : Single-issue ALU element with an IDLE/EXEC/DONE FSM.
//                Operands are captured on the accepting edge into operand
//                registers; the result register is written one edge later
//                from those registers (a pending-write stage). MUL runs in
//                the pe_multiplier sub-module for DATA_W cycles in EXEC, then
//                uses the same pending-write stage on the way to DONE.
//  Ports       : clock, reset   - rising-edge clock, async active-high reset
//                en_pe          - operation-issue strobe
//                ctrl           - control word (ctrl.op selects the op)
//                op_a, op_b     - DATA_W-bit operands
//                en_out         - result-consume strobe
//                ready          - issue can be accepted (decoded from state)
//                result         - registered RES_W-bit result
//                result_valid   - result holds an unconsumed value
//  Revision    : 1.0 - initial release
// ============================================================================
module processing_element
  import internal_defines::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en_pe,
  input  ctrl_signals_t       ctrl,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic                en_out,
  output logic                ready,
  output logic [RES_W-1:0]    result,
  output logic                result_valid
);

  pe_state_t           state_q,  state_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                valid_q,  valid_d;
  pe_op_t              op_q,     op_d;
  logic [DATA_W-1:0]   a_q,      a_d;
  logic [DATA_W-1:0]   b_q,      b_d;
  // A result computed from the operand registers lands on the next edge.
  logic                pend_q,   pend_d;

  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic [RES_W-1:0]    alu_out;
  logic [RES_W-1:0]    a_ext;
  logic [RES_W-1:0]    b_ext;

  assign ready        = (state_q != EXEC);
  assign accept       = en_pe && ready;
  assign result       = result_q;
  assign result_valid = valid_q;

  assign a_ext = {{(RES_W-DATA_W){1'b0}}, a_q};
  assign b_ext = {{(RES_W-DATA_W){1'b0}}, b_q};

  pe_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_out = '0;
    case (op_q)
      ADD:     alu_out = a_ext + b_ext;
      SUB:     alu_out = a_ext - b_ext;
      AND:     alu_out = a_ext & b_ext;
      OR:      alu_out = a_ext | b_ext;
      XOR:     alu_out = a_ext ^ b_ext;
      PASS:    alu_out = a_ext;
      MUL:     alu_out = RES_W'(mul_product);
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    valid_d   = valid_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    pend_d    = 1'b0;
    mul_start = 1'b0;

    if (pend_q) begin
      result_d = alu_out;
      valid_d  = 1'b1;
    end

    case (state_q)
      IDLE: begin
      end
      EXEC: begin
        if (mul_done) begin
          state_d = DONE;
          pend_d  = 1'b1;
        end
      end
      DONE: begin
        // A landing result is fresh, so consumption only affects an old one.
        if (en_out && !pend_q) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted issue overrides any consumption-driven state change.
    if (accept && (ctrl.op != NOP)) begin
      if (is_multi_cycle(ctrl.op)) begin
        op_d      = ctrl.op;
        mul_start = 1'b1;
        valid_d   = 1'b0;
        state_d   = EXEC;
      end else begin
        op_d    = ctrl.op;
        a_d     = op_a;
        b_d     = op_b;
        pend_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      op_q     <= NOP;
      a_q      <= '0;
      b_q      <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pend_q   <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_processing_element.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processing_element
//  Description : Self-checking bench for processing_element: directed vector
//                table, hand-written multi-cycle/reset sequences and random
//                transactions checked against a plain-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_processing_element;
  import internal_defines::*;

  localparam int DATA_W = 4;
  localparam int RES_W  = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                en_pe;
  ctrl_signals_t       ctrl;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                en_out;
  logic                ready;
  logic [RES_W-1:0]    result;
  logic                result_valid;

  int n_pass  = 0;
  int n_total = 0;

  logic [RES_W-1:0] exp_result;
  logic             exp_valid;

  typedef struct {
    pe_op_t           op;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             co;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs [12];

  processing_element #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .en_pe        (en_pe),
    .ctrl         (ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .en_out       (en_out),
    .ready        (ready),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [7:0] ref_result(input pe_op_t op, input logic [3:0] a, input logic [3:0] b);
    int x = a;
    int y = b;
    int r;
    case (op)
      ADD:     r = x + y;
      SUB:     r = x - y;
      AND:     r = x & y;
      OR:      r = x | y;
      XOR:     r = x ^ y;
      MUL:     r = x * y;
      PASS:    r = x;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Issue one op (optionally with a simultaneous consume) and follow it to
  // completion. Called just after a rising edge with the DUT ready.
  task automatic run_op(input pe_op_t op, input logic [3:0] a, input logic [3:0] b,
                        input logic co, input logic [7:0] exp, input string nm);
    en_pe   = 1'b1;
    ctrl.op = op;
    op_a    = a;
    op_b    = b;
    en_out  = co;
    @(posedge clock); #1;
    en_pe   = 1'b0;
    en_out  = 1'b0;
    // Scramble the issue inputs: the accepted values must already be held.
    ctrl.op = pe_op_t'(3'($urandom_range(0, 7)));
    op_a    = 4'($urandom_range(0, 15));
    op_b    = 4'($urandom_range(0, 15));
    if (co) exp_valid = 1'b0;
    if (op == NOP) begin
      check({nm, " nop valid"}, result_valid, exp_valid);
      check({nm, " nop result"}, result, exp_result);
      check({nm, " nop ready"}, ready, 1);
    end else if (op == MUL) begin
      exp_valid = 1'b0;
      check({nm, " mul ready0"}, ready, 0);
      check({nm, " mul valid0"}, result_valid, 0);
      en_pe   = 1'b1;
      ctrl.op = ADD;
      op_a    = 4'd1;
      op_b    = 4'd1;
      for (int k = 1; k < DATA_W; k++) begin
        @(posedge clock); #1;
        if (k == DATA_W - 1) en_pe = 1'b0;
        check({nm, " mul busy ready"}, ready, 0);
        check({nm, " mul busy valid"}, result_valid, 0);
      end
      @(posedge clock); #1;
      check({nm, " mul done ready"}, ready, 1);
      check({nm, " mul done valid"}, result_valid, 0);
      @(posedge clock); #1;
      check({nm, " mul result"}, result, exp);
      check({nm, " mul valid"}, result_valid, 1);
      exp_result = exp;
      exp_valid  = 1'b1;
    end else begin
      check({nm, " accept ready"}, ready, 1);
      check({nm, " accept valid"}, result_valid, exp_valid);
      check({nm, " accept result"}, result, exp_result);
      @(posedge clock); #1;
      check({nm, " result"}, result, exp);
      check({nm, " valid"}, result_valid, 1);
      exp_result = exp;
      exp_valid  = 1'b1;
    end
  endtask

  task automatic consume(input string nm);
    en_out = 1'b1;
    @(posedge clock); #1;
    en_out    = 1'b0;
    exp_valid = 1'b0;
    check({nm, " consume valid"}, result_valid, 0);
    check({nm, " consume result"}, result, exp_result);
    check({nm, " consume ready"}, ready, 1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset      = 1'b0;
    exp_result = '0;
    exp_valid  = 1'b0;
  endtask

  initial begin
    pe_op_t     rop;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rco;

    vecs[0]  = '{SUB,  4'h3, 4'h5, 1'b0, 8'hFE};
    vecs[1]  = '{XOR,  4'hA, 4'h6, 1'b0, 8'h0C};
    vecs[2]  = '{AND,  4'hC, 4'hA, 1'b1, 8'h08};
    vecs[3]  = '{OR,   4'h5, 4'hA, 1'b0, 8'h0F};
    vecs[4]  = '{PASS, 4'h7, 4'h3, 1'b0, 8'h07};
    vecs[5]  = '{ADD,  4'hF, 4'hF, 1'b0, 8'h1E};
    vecs[6]  = '{SUB,  4'h0, 4'hF, 1'b1, 8'hF1};
    vecs[7]  = '{MUL,  4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[8]  = '{ADD,  4'h1, 4'h1, 1'b1, 8'h02};
    vecs[9]  = '{MUL,  4'h3, 4'h5, 1'b0, 8'h0F};
    vecs[10] = '{NOP,  4'h9, 4'h9, 1'b0, 8'h00};
    vecs[11] = '{MUL,  4'h0, 4'h9, 1'b1, 8'h00};

    en_pe   = 1'b0;
    en_out  = 1'b0;
    ctrl.op = NOP;
    op_a    = '0;
    op_b    = '0;

    // Reset state, then the very first edge after release accepts ADD 9+8.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset result", result, 0);
    check("reset valid", result_valid, 0);
    check("reset ready", ready, 1);
    reset      = 1'b0;
    exp_result = '0;
    exp_valid  = 1'b0;
    run_op(ADD, 4'h9, 4'h8, 1'b0, 8'h11, "add9+8");
    consume("add9+8");

    // NOP and consume pulses in IDLE leave everything at reset values.
    apply_reset();
    run_op(NOP, 4'h5, 4'h3, 1'b0, 8'h00, "idle nop");
    consume("idle");
    check("idle result zero", result, 0);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].co, vecs[i].exp, $sformatf("vec%0d", i));
    end
    consume("vec end");

    // Reset in the middle of MUL 7*7 aborts it immediately.
    run_op(ADD, 4'h5, 4'h6, 1'b0, 8'h0B, "pre-abort");
    en_pe   = 1'b1;
    ctrl.op = MUL;
    op_a    = 4'h7;
    op_b    = 4'h7;
    @(posedge clock); #1;
    en_pe = 1'b0;
    check("abort exec ready", ready, 0);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("abort result", result, 0);
    check("abort valid", result_valid, 0);
    check("abort ready", ready, 1);
    @(posedge clock); #1;
    reset      = 1'b0;
    exp_result = '0;
    exp_valid  = 1'b0;
    repeat (DATA_W + 2) @(posedge clock);
    #1;
    check("abort no partial", result, 0);
    check("abort no valid", result_valid, 0);
    run_op(ADD, 4'h2, 4'h2, 1'b0, 8'h04, "post-abort");

    // Random transactions against the arithmetic model.
    for (int t = 0; t < 40; t++) begin
      rop = pe_op_t'(3'($urandom_range(0, 7)));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rco = 1'($urandom_range(0, 1));
      run_op(rop, ra, rb, rco, ref_result(rop, ra, rb), $sformatf("rand%0d", t));
      if ($urandom_range(0, 3) == 0) consume($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
